// File: rtl/datapath_io_pkg.sv
// rtl/datapath_io_pkg.sv - shared bus-select codes, ALU opcodes and flag bit positions
package datapath_io_pkg;

  localparam logic [1:0] BUS1_PC   = 2'b00;
  localparam logic [1:0] BUS1_A    = 2'b01;
  localparam logic [1:0] BUS1_B    = 2'b10;
  localparam logic [1:0] BUS1_ZERO = 2'b11;

  localparam logic [1:0] BUS2_ALU  = 2'b00;
  localparam logic [1:0] BUS2_BUS1 = 2'b01;
  localparam logic [1:0] BUS2_MEM  = 2'b10;
  localparam logic [1:0] BUS2_ZERO = 2'b11;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_AND  = 4'h2;
  localparam logic [3:0] ALU_OR   = 4'h3;
  localparam logic [3:0] ALU_XOR  = 4'h4;
  localparam logic [3:0] ALU_NOT  = 4'h5;
  localparam logic [3:0] ALU_SHL  = 4'h6;
  localparam logic [3:0] ALU_SHR  = 4'h7;
  localparam logic [3:0] ALU_MUL  = 4'h8;
  localparam logic [3:0] ALU_DIV  = 4'h9;
  localparam logic [3:0] ALU_MOD  = 4'hA;
  localparam logic [3:0] ALU_EQ   = 4'hB;
  localparam logic [3:0] ALU_BCLR = 4'hC;
  localparam logic [3:0] ALU_BSET = 4'hD;

  localparam int FLAG_N = 7;
  localparam int FLAG_Z = 6;
  localparam int FLAG_C = 5;
  localparam int FLAG_P = 4;
  localparam int FLAG_V = 1;

endpackage

// File: rtl/datapath_io_alu.sv
// rtl/datapath_io_alu.sv - combinational ALU (X = Bus1, Y = B) with flag generation
module dp_alu
  import datapath_io_pkg::*;
(
  input  logic [3:0] alu_sel,
  input  logic [7:0] x,
  input  logic [7:0] y,
  output logic [7:0] result,
  output logic [7:0] flags
);

  logic [8:0]  sum;
  logic [15:0] prod;
  logic [7:0]  bit_mask;
  logic        carry;
  logic        overflow;

  assign sum      = {1'b0, x} + {1'b0, y};
  assign prod     = {8'h00, x} * {8'h00, y};
  assign bit_mask = 8'h01 << y[2:0];

  always_comb begin
    result   = 8'h00;
    carry    = 1'b0;
    overflow = 1'b0;
    case (alu_sel)
      ALU_ADD: begin
        result   = sum[7:0];
        carry    = sum[8];
        overflow = (x[7] == y[7]) && (result[7] != x[7]);
      end
      ALU_SUB: begin
        result   = x - y;
        carry    = (x < y);
        overflow = (x[7] != y[7]) && (result[7] != x[7]);
      end
      ALU_AND:  result = x & y;
      ALU_OR:   result = x | y;
      ALU_XOR:  result = x ^ y;
      ALU_NOT:  result = ~x;
      ALU_SHL: begin
        result = {x[6:0], 1'b0};
        carry  = x[7];
      end
      ALU_SHR: begin
        result = {1'b0, x[7:1]};
        carry  = x[0];
      end
      ALU_MUL:  result = prod[7:0];
      // divide/modulo by zero saturate to all-ones instead of trapping
      ALU_DIV:  result = (y == 8'h00) ? 8'hFF : x / y;
      ALU_MOD:  result = (y == 8'h00) ? 8'hFF : x % y;
      ALU_EQ:   result = (x == y) ? 8'h01 : 8'h00;
      ALU_BCLR: result = x & ~bit_mask;
      ALU_BSET: result = x | bit_mask;
      default:  result = 8'h00;
    endcase
  end

  always_comb begin
    flags         = 8'h00;
    flags[FLAG_N] = result[7];
    flags[FLAG_Z] = (result == 8'h00);
    flags[FLAG_C] = carry;
    flags[FLAG_P] = ^result;
    flags[FLAG_V] = overflow;
  end

endmodule

// File: rtl/datapath_io.sv
// rtl/datapath_io.sv - 8-bit datapath registers, bus muxes, ALU and memory-mapped output port
module datapath_io
  import datapath_io_pkg::*;
#(
  parameter logic [7:0] PORT_ADDR = 8'hE0,
  parameter logic [7:0] PC_RESET  = 8'h00
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] bus1_sel,
  input  logic [1:0] bus2_sel,
  input  logic [3:0] alu_sel,
  input  logic       PC_inc,
  input  logic       PC_load,
  input  logic       MAR_load,
  input  logic       IR_load,
  input  logic       A_load,
  input  logic       B_load,
  input  logic       CCR_load,
  input  logic       write,
  input  logic [7:0] dado_mem,
  output logic [7:0] endereco_mem,
  output logic [7:0] dado_para_mem,
  output logic [7:0] IR,
  output logic [7:0] NZVC,
  output logic [7:0] saida
);

  logic [7:0] pc;
  logic [7:0] mar;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] bus1;
  logic [7:0] bus2;
  logic [7:0] alu_result;
  logic [7:0] alu_flags;
  logic       port_write;

  always_comb begin
    bus1 = 8'h00;
    case (bus1_sel)
      BUS1_PC:  bus1 = pc;
      BUS1_A:   bus1 = a;
      BUS1_B:   bus1 = b;
      default:  bus1 = 8'h00;
    endcase
  end

  always_comb begin
    bus2 = 8'h00;
    case (bus2_sel)
      BUS2_ALU:  bus2 = alu_result;
      BUS2_BUS1: bus2 = bus1;
      BUS2_MEM:  bus2 = dado_mem;
      default:   bus2 = 8'h00;
    endcase
  end

  dp_alu u_alu (
    .alu_sel (alu_sel),
    .x       (bus1),
    .y       (b),
    .result  (alu_result),
    .flags   (alu_flags)
  );

  // port decode uses the MAR value present before this edge's load
  assign port_write = write && (mar == PORT_ADDR);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc    <= PC_RESET;
      mar   <= 8'h00;
      IR    <= 8'h00;
      a     <= 8'h00;
      b     <= 8'h00;
      NZVC  <= 8'h00;
      saida <= 8'h00;
    end else begin
      if (PC_load)      pc <= bus2;
      else if (PC_inc)  pc <= pc + 8'd1;
      if (MAR_load)     mar   <= bus2;
      if (IR_load)      IR    <= bus2;
      if (A_load)       a     <= bus2;
      if (B_load)       b     <= bus2;
      if (CCR_load)     NZVC  <= alu_flags;
      if (port_write)   saida <= bus1;
    end
  end

  assign endereco_mem  = mar;
  assign dado_para_mem = bus1;

endmodule

// File: tb/tb_datapath_io.sv
// tb/tb_datapath_io.sv - directed and random checks of datapath_io against an arithmetic model
module tb_datapath_io;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] bus1_sel = 2'b00;
  logic [1:0] bus2_sel = 2'b00;
  logic [3:0] alu_sel = 4'h0;
  logic       PC_inc = 1'b0, PC_load = 1'b0, MAR_load = 1'b0, IR_load = 1'b0;
  logic       A_load = 1'b0, B_load = 1'b0, CCR_load = 1'b0, write = 1'b0;
  logic [7:0] dado_mem = 8'h00;
  logic [7:0] endereco_mem, dado_para_mem, IR, NZVC, saida;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] m_pc, m_mar, m_ir, m_a, m_b, m_ccr, m_saida;

  datapath_io dut (
    .clock(clock), .reset(reset), .bus1_sel(bus1_sel), .bus2_sel(bus2_sel),
    .alu_sel(alu_sel), .PC_inc(PC_inc), .PC_load(PC_load), .MAR_load(MAR_load),
    .IR_load(IR_load), .A_load(A_load), .B_load(B_load), .CCR_load(CCR_load),
    .write(write), .dado_mem(dado_mem), .endereco_mem(endereco_mem),
    .dado_para_mem(dado_para_mem), .IR(IR), .NZVC(NZVC), .saida(saida)
  );

  always #5 clock = ~clock;

  function automatic int to_signed8(int v);
    return (v > 127) ? v - 256 : v;
  endfunction

  // returns {flags, result} computed from the arithmetic definition of each op
  function automatic logic [15:0] alu_ref(logic [3:0] op, logic [7:0] x, logic [7:0] y);
    int xi = x;
    int yi = y;
    int r = 0;
    int c = 0;
    int v = 0;
    int s = 0;
    int bitv = 1 << (yi % 8);
    int ones = 0;
    logic [7:0] res;
    logic [7:0] fl;
    case (op)
      4'h0: begin r = xi + yi; c = (r > 255); s = to_signed8(xi) + to_signed8(yi); v = (s > 127 || s < -128); end
      4'h1: begin r = xi - yi; c = (xi < yi); s = to_signed8(xi) - to_signed8(yi); v = (s > 127 || s < -128); end
      4'h2: r = xi & yi;
      4'h3: r = xi | yi;
      4'h4: r = xi ^ yi;
      4'h5: r = 255 - xi;
      4'h6: begin r = xi * 2; c = (xi >= 128); end
      4'h7: begin r = xi / 2; c = xi % 2; end
      4'h8: r = xi * yi;
      4'h9: if (yi == 0) r = 255; else r = xi / yi;
      4'hA: if (yi == 0) r = 255; else r = xi % yi;
      4'hB: r = (xi == yi) ? 1 : 0;
      4'hC: r = ((xi / bitv) % 2 == 1) ? xi - bitv : xi;
      4'hD: r = ((xi / bitv) % 2 == 1) ? xi : xi + bitv;
      default: r = 0;
    endcase
    r = ((r % 256) + 256) % 256;
    for (int i = 0; i < 8; i++) ones += (r >> i) & 1;
    res = r[7:0];
    fl = 8'h00;
    if (r >= 128) fl = fl + 8'h80;
    if (r == 0) fl = fl + 8'h40;
    if (c != 0) fl = fl + 8'h20;
    if (ones % 2 == 1) fl = fl + 8'h10;
    if (v != 0) fl = fl + 8'h02;
    return {fl, res};
  endfunction

  function automatic logic [7:0] m_bus1(logic [1:0] sel);
    case (sel)
      2'd0: return m_pc;
      2'd1: return m_a;
      2'd2: return m_b;
      default: return 8'h00;
    endcase
  endfunction

  task automatic check(string tag, logic [7:0] observed, logic [7:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic clear_ctl();
    bus1_sel = 2'b00; bus2_sel = 2'b00; alu_sel = 4'h0;
    PC_inc = 0; PC_load = 0; MAR_load = 0; IR_load = 0;
    A_load = 0; B_load = 0; CCR_load = 0; write = 0; dado_mem = 8'h00;
  endtask

  task automatic model_reset();
    m_pc = 8'h00; m_mar = 8'h00; m_ir = 8'h00; m_a = 8'h00;
    m_b = 8'h00; m_ccr = 8'h00; m_saida = 8'h00;
  endtask

  // shows PC, A and B on dado_para_mem without clocking; leaves controls cleared
  task automatic peek(string tag);
    write = 0;
    bus1_sel = 2'd0; #1 check({tag, "_pc"}, dado_para_mem, m_pc);
    bus1_sel = 2'd1; #1 check({tag, "_a"}, dado_para_mem, m_a);
    bus1_sel = 2'd2; #1 check({tag, "_b"}, dado_para_mem, m_b);
    clear_ctl();
  endtask

  task automatic step(string tag);
    logic [7:0]  b1;
    logic [15:0] ar;
    logic [7:0]  b2;
    b1 = m_bus1(bus1_sel);
    ar = alu_ref(alu_sel, b1, m_b);
    case (bus2_sel)
      2'd0: b2 = ar[7:0];
      2'd1: b2 = b1;
      2'd2: b2 = dado_mem;
      default: b2 = 8'h00;
    endcase
    @(posedge clock);
    #1;
    if (write && m_mar == 8'hE0) m_saida = b1;
    if (PC_load) m_pc = b2;
    else if (PC_inc) m_pc = 8'((int'(m_pc) + 1) % 256);
    if (MAR_load) m_mar = b2;
    if (IR_load) m_ir = b2;
    if (A_load) m_a = b2;
    if (B_load) m_b = b2;
    if (CCR_load) m_ccr = ar[15:8];
    check({tag, "_mar"}, endereco_mem, m_mar);
    check({tag, "_ir"}, IR, m_ir);
    check({tag, "_ccr"}, NZVC, m_ccr);
    check({tag, "_saida"}, saida, m_saida);
    peek(tag);
  endtask

  task automatic load_mem(logic [7:0] v, logic to_a, logic to_b, logic to_mar, logic to_pc);
    clear_ctl();
    bus2_sel = 2'd2; dado_mem = v;
    A_load = to_a; B_load = to_b; MAR_load = to_mar; PC_load = to_pc;
    step("load");
  endtask

  initial begin
    model_reset();
    clear_ctl();
    repeat (2) @(posedge clock);
    #1;
    check("rst_mar", endereco_mem, 8'h00);
    check("rst_ccr", NZVC, 8'h00);
    check("rst_saida", saida, 8'h00);
    peek("rst");
    @(negedge clock);
    reset = 1'b1;

    // fetch: MAR <= PC, then PC+1, then IR <= memory
    bus1_sel = 2'd0; bus2_sel = 2'd1; MAR_load = 1; step("fetch_mar");
    clear_ctl(); PC_inc = 1; step("fetch_inc");
    check("fetch_pc_is_01", m_pc, 8'h01);
    clear_ctl(); bus2_sel = 2'd2; dado_mem = 8'h86; IR_load = 1; step("fetch_ir");
    check("fetch_ir_86", IR, 8'h86);

    // add with signed overflow: 7F + 01
    load_mem(8'h7F, 1, 0, 0, 0);
    load_mem(8'h01, 0, 1, 0, 0);
    clear_ctl(); bus1_sel = 2'd1; alu_sel = 4'h0; A_load = 1; CCR_load = 1; step("add_ovf");
    check("add_ovf_a", m_a, 8'h80);
    check("add_ovf_flags", NZVC, 8'h92);

    // add with carry to zero: FF + 01
    load_mem(8'hFF, 1, 0, 0, 0);
    clear_ctl(); bus1_sel = 2'd1; alu_sel = 4'h0; A_load = 1; CCR_load = 1; step("add_carry");
    check("add_carry_flags", NZVC, 8'h60);

    // divide by zero
    load_mem(8'h10, 1, 0, 0, 0);
    load_mem(8'h00, 0, 1, 0, 0);
    clear_ctl(); bus1_sel = 2'd1; alu_sel = 4'h9; A_load = 1; CCR_load = 1; step("div0");
    check("div0_a", m_a, 8'hFF);
    check("div0_flags", NZVC, 8'h80);

    // equality
    load_mem(8'h55, 1, 1, 0, 0);
    clear_ctl(); bus1_sel = 2'd1; alu_sel = 4'hB; A_load = 1; CCR_load = 1; step("eq");
    check("eq_a", m_a, 8'h01);

    // output port hit, then miss
    load_mem(8'hE0, 0, 0, 1, 0);
    load_mem(8'hAA, 1, 0, 0, 0);
    clear_ctl(); bus1_sel = 2'd1; write = 1; step("port_hit");
    check("port_hit_aa", saida, 8'hAA);
    load_mem(8'h90, 0, 0, 1, 0);
    load_mem(8'h55, 1, 0, 0, 0);
    clear_ctl(); bus1_sel = 2'd1; write = 1; step("port_miss");
    check("port_miss_aa", saida, 8'hAA);

    // PC_load beats PC_inc; PC wraps
    clear_ctl(); bus2_sel = 2'd2; dado_mem = 8'h42; PC_load = 1; PC_inc = 1; step("pc_load");
    check("pc_load_42", m_pc, 8'h42);
    load_mem(8'hFF, 0, 0, 0, 1);
    clear_ctl(); PC_inc = 1; step("pc_wrap");
    check("pc_wrap_00", m_pc, 8'h00);

    // asynchronous reset mid-run
    load_mem(8'h3C, 1, 1, 1, 1);
    clear_ctl(); bus2_sel = 2'd2; dado_mem = 8'h77; IR_load = 1; CCR_load = 1; step("pre_rst");
    #1 reset = 1'b0;
    #1;
    model_reset();
    check("arst_mar", endereco_mem, 8'h00);
    check("arst_ir", IR, 8'h00);
    check("arst_ccr", NZVC, 8'h00);
    check("arst_saida", saida, 8'h00);
    peek("arst");
    @(negedge clock);
    reset = 1'b1;

    // random traffic
    for (int i = 0; i < 300; i++) begin
      clear_ctl();
      bus1_sel = 2'($urandom_range(0, 3));
      bus2_sel = 2'($urandom_range(0, 3));
      alu_sel  = 4'($urandom_range(0, 15));
      PC_inc   = 1'($urandom_range(0, 1));
      PC_load  = ($urandom_range(0, 3) == 0);
      MAR_load = ($urandom_range(0, 2) == 0);
      IR_load  = 1'($urandom_range(0, 1));
      A_load   = 1'($urandom_range(0, 1));
      B_load   = ($urandom_range(0, 2) == 0);
      CCR_load = 1'($urandom_range(0, 1));
      write    = 1'($urandom_range(0, 1));
      dado_mem = ($urandom_range(0, 3) == 0) ? 8'hE0 : 8'($urandom);
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
